// File: rtl/output_buffer_pkg.sv
// Shared FSM state encoding and request-mode constants for the KxK window output buffer.
package output_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } obuf_state_e;

   localparam logic MODE_KXK = 1'b0;
   localparam logic MODE_1X1 = 1'b1;

endpackage

// File: rtl/obuf_sdp_ram.sv
// Simple dual-port pixel store: one write port, one registered read port, read-first on collision.
module obuf_sdp_ram #(
   parameter int    WIDTH     = 24,
   parameter int    DEPTH     = 25,
   parameter int    AW        = 5,
   parameter string RAM_STYLE = "auto"
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Both accesses in one process: a same-address read samples the pre-write word.
   always_ff @(posedge clk) begin
      if (we_i && (32'(waddr_i) < DEPTH)) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/output_buffer_kxk.sv
// Gathers a zero-padded KxK (or centre-only) window of multi-channel pixels from an unpadded map.
module output_buffer_kxk
   import output_buffer_pkg::*;
#(
   parameter int    DATA_WIDTH   = 8,
   parameter int    OUT_CHANNELS = 3,
   parameter int    IN_WIDTH     = 5,
   parameter int    IN_HEIGHT    = 5,
   parameter int    KERNEL       = 3,
   parameter string RAM_STYLE    = "auto",
   localparam int   NPIX         = IN_WIDTH * IN_HEIGHT,
   localparam int   AW           = $clog2(NPIX),
   localparam int   PW           = DATA_WIDTH * OUT_CHANNELS,
   localparam int   KK           = KERNEL * KERNEL
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wr_addr_i,
   input  logic [PW-1:0]      wr_data_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [AW-1:0]      req_addr_i,
   input  logic               req_mode_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [KK*PW-1:0]   out_data_o,
   output logic               out_err_o
);

   localparam int PAD  = (KERNEL - 1) / 2;
   localparam int CTAP = (KK - 1) / 2;
   localparam int CW   = AW + 3;
   localparam int TW   = (KK > 1) ? $clog2(KK) : 1;
   localparam int DXW  = (KERNEL > 1) ? $clog2(KERNEL) : 1;

   localparam logic signed [CW-1:0] H_S   = CW'(IN_HEIGHT);
   localparam logic signed [CW-1:0] W_S   = CW'(IN_WIDTH);
   localparam logic signed [CW-1:0] ONE_S = CW'(1);
   localparam logic signed [CW-1:0] KM1_S = CW'(KERNEL - 1);
   localparam logic [AW-1:0]        ROWSTEP = AW'(IN_WIDTH - KERNEL + 1);
   localparam logic [AW:0]          NPIX_L  = (AW+1)'(NPIX);

   obuf_state_e            state_q, state_d;
   logic                   mode_q, mode_d;
   logic signed [CW-1:0]   tr_q, tr_d, tc_q, tc_d;
   logic [AW-1:0]          ra_q, ra_d;
   logic [TW-1:0]          tap_q, tap_d;
   logic [DXW-1:0]         dx_q, dx_d;
   logic                   err_q, err_d;
   logic                   ovld_q, ovld_d;
   logic                   cap_vld_q;
   logic [TW-1:0]          cap_tap_q;
   logic [KK-1:0][PW-1:0]  slot_q;

   logic                   clr_slots, in_map, rd_en, last_tap, addr_oor;
   logic [PW-1:0]          rd_data;
   int                     a_int, crow, ccol;

   assign addr_oor = {1'b0, req_addr_i} >= NPIX_L;
   // Tap row/col are tracked signed so padding positions fall outside [0,H)x[0,W).
   assign in_map   = !tr_q[CW-1] && (tr_q < H_S) && !tc_q[CW-1] && (tc_q < W_S);

   always_comb begin
      a_int = int'(req_addr_i);
      crow  = a_int / IN_WIDTH;
      ccol  = a_int % IN_WIDTH;
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      tr_d      = tr_q;
      tc_d      = tc_q;
      ra_d      = ra_q;
      tap_d     = tap_q;
      dx_d      = dx_q;
      err_d     = err_q;
      ovld_d    = 1'b0;
      clr_slots = 1'b0;
      rd_en     = 1'b0;
      last_tap  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               clr_slots = 1'b1;
               mode_d    = req_mode_i;
               err_d     = addr_oor;
               if (addr_oor) begin
                  state_d = HOLD;
               end else begin
                  state_d = FETCH;
                  if (req_mode_i == MODE_1X1) begin
                     tap_d = TW'(CTAP);
                     dx_d  = DXW'(PAD);
                     tr_d  = CW'(crow);
                     tc_d  = CW'(ccol);
                     ra_d  = req_addr_i;
                  end else begin
                     tap_d = '0;
                     dx_d  = '0;
                     tr_d  = CW'(crow - PAD);
                     tc_d  = CW'(ccol - PAD);
                     // Modulo-2^AW address is only consumed for in-map taps, where it is exact.
                     ra_d  = AW'(a_int - PAD * IN_WIDTH - PAD);
                  end
               end
            end
         end
         FETCH: begin
            rd_en    = in_map;
            last_tap = (mode_q == MODE_1X1) || (tap_q == TW'(KK - 1));
            if (last_tap) begin
               state_d = HOLD;
            end else begin
               tap_d = tap_q + 1'b1;
               if (dx_q == DXW'(KERNEL - 1)) begin
                  dx_d = '0;
                  tr_d = tr_q + ONE_S;
                  tc_d = tc_q - KM1_S;
                  ra_d = ra_q + ROWSTEP;
               end else begin
                  dx_d = dx_q + 1'b1;
                  tc_d = tc_q + ONE_S;
                  ra_d = ra_q + 1'b1;
               end
            end
         end
         HOLD: begin
            // Valid rises one cycle into HOLD, together with the last landed tap.
            ovld_d = 1'b1;
            if (ovld_q && out_ready_i) begin
               state_d = IDLE;
               ovld_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mode_q    <= MODE_KXK;
         tr_q      <= '0;
         tc_q      <= '0;
         ra_q      <= '0;
         tap_q     <= '0;
         dx_q      <= '0;
         err_q     <= 1'b0;
         ovld_q    <= 1'b0;
         cap_vld_q <= 1'b0;
         cap_tap_q <= '0;
         slot_q    <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         tr_q      <= tr_d;
         tc_q      <= tc_d;
         ra_q      <= ra_d;
         tap_q     <= tap_d;
         dx_q      <= dx_d;
         err_q     <= err_d;
         ovld_q    <= ovld_d;
         cap_vld_q <= rd_en;
         cap_tap_q <= tap_q;
         if (clr_slots)      slot_q <= '0;
         else if (cap_vld_q) slot_q[cap_tap_q] <= rd_data;
      end
   end

   obuf_sdp_ram #(
      .WIDTH     (PW),
      .DEPTH     (NPIX),
      .AW        (AW),
      .RAM_STYLE (RAM_STYLE)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en_i),
      .waddr_i (wr_addr_i),
      .wdata_i (wr_data_i),
      .re_i    (rd_en),
      .raddr_i (ra_q),
      .rdata_o (rd_data)
   );

   assign req_ready_o = (state_q == IDLE);
   assign out_valid_o = ovld_q;
   assign out_err_o   = err_q;
   assign out_data_o  = slot_q;

endmodule

// File: tb/tb_output_buffer_kxk.sv
// Self-checking bench for output_buffer_kxk: vector table, corner sequences and random requests vs a window model.
module tb_output_buffer_kxk;

   localparam int AW = 5;
   localparam int PW = 24;
   localparam int KK = 9;
   localparam int OW = KK * PW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [PW-1:0] wr_data = '0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          req_mode = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [OW-1:0] out_data;
   logic          out_err;

   int errors = 0;
   int checks = 0;
   logic [PW-1:0] mem_m [25];

   always #5 clk = ~clk;

   output_buffer_kxk dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en_i     (wr_en),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_addr_i  (req_addr),
      .req_mode_i  (req_mode),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_err_o   (out_err)
   );

   typedef struct {
      int          addr;
      logic        mode;
      int          lat;
      logic        err;
      logic [23:0] ctr;
   } vec_t;

   task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Window built tap by tap from map geometry; pixels outside the map are zero.
   function automatic logic [OW-1:0] win(input int a, input logic m);
      logic [OW-1:0] r;
      int y, x;
      r = '0;
      if (a >= 25) return r;
      for (int t = 0; t < KK; t++) begin
         y = a / 5 + t / 3 - 1;
         x = a % 5 + t % 3 - 1;
         if (!(m && t != 4) && y >= 0 && y < 5 && x >= 0 && x < 5)
            r[t*PW +: PW] = mem_m[y*5+x];
      end
      return r;
   endfunction

   task automatic wr_pix(input int a, input logic [PW-1:0] d);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      @(posedge clk); #1 wr_en = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic finish_req(input logic [OW-1:0] exp_d, input logic exp_e, input int exp_lat,
                             input int edges_done, input int hold, input string nm,
                             output logic [OW-1:0] got);
      int lat;
      lat = edges_done;
      while (lat < 60) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (out_valid) break;
      end
      chk({nm, "_lat"}, OW'(lat), OW'(exp_lat));
      chk({nm, "_data"}, out_data, exp_d);
      chk({nm, "_err"}, OW'(out_err), OW'(exp_e));
      got = out_data;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); @(negedge clk);
         chk({nm, "_hold_data"}, out_data, exp_d);
         chk({nm, "_hold_rdy"}, OW'(req_ready), OW'(0));
         chk({nm, "_hold_vld"}, OW'(out_valid), OW'(1));
      end
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk({nm, "_done_vld"}, OW'(out_valid), OW'(0));
      chk({nm, "_done_rdy"}, OW'(req_ready), OW'(1));
      @(negedge clk);
   endtask

   task automatic run_req(input int a, input logic m, input int hold, input string nm,
                          output logic [OW-1:0] got);
      logic [OW-1:0] exp_d;
      int exp_lat;
      exp_d   = win(a, m);
      exp_lat = (a >= 25) ? 1 : (m ? 2 : 10);
      chk({nm, "_rdy"}, OW'(req_ready), OW'(1));
      req_valid = 1'b1; req_addr = AW'(a); req_mode = m;
      @(posedge clk); #1 req_valid = 1'b0;
      finish_req(exp_d, a >= 25, exp_lat, 0, hold, nm, got);
   endtask

   initial begin
      vec_t vecs [7];
      logic [OW-1:0] got, exp_d;
      int ra;
      logic rm;

      vecs[0] = '{12, 1'b0, 10, 1'b0, 24'h323130};
      vecs[1] = '{0,  1'b0, 10, 1'b0, 24'h020100};
      vecs[2] = '{7,  1'b1, 2,  1'b0, 24'h1e1d1c};
      vecs[3] = '{24, 1'b0, 10, 1'b0, 24'h626160};
      vecs[4] = '{25, 1'b0, 1,  1'b1, 24'h000000};
      vecs[5] = '{4,  1'b1, 2,  1'b0, 24'h121110};
      vecs[6] = '{20, 1'b0, 10, 1'b0, 24'h525150};

      #3;
      chk("rst_vld", OW'(out_valid), OW'(0));
      chk("rst_err", OW'(out_err), OW'(0));
      chk("rst_data", out_data, '0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_rdy", OW'(req_ready), OW'(1));
      @(negedge clk);
      for (int p = 0; p < 25; p++)
         wr_pix(p, {8'(4*p+2), 8'(4*p+1), 8'(4*p)});
      @(negedge clk);

      foreach (vecs[i]) begin
         chk($sformatf("vec%0d_rdy", i), OW'(req_ready), OW'(1));
         req_valid = 1'b1; req_addr = AW'(vecs[i].addr); req_mode = vecs[i].mode;
         @(posedge clk); #1 req_valid = 1'b0;
         finish_req(win(vecs[i].addr, vecs[i].mode), vecs[i].err, vecs[i].lat, 0, 0,
                    $sformatf("vec%0d", i), got);
         chk($sformatf("vec%0d_ctr", i), OW'(got[4*PW +: PW]), OW'(vecs[i].ctr));
      end
      chk("corner_zero", OW'({got[0 +: PW], 48'h0}), '0);
      run_req(0, 1'b0, 0, "corner", got);
      chk("corner_pad", OW'({got[0*PW +: PW], got[1*PW +: PW], got[2*PW +: PW],
                             got[3*PW +: PW], got[6*PW +: PW]}), '0);
      chk("corner_map", OW'({got[8*PW +: PW], got[7*PW +: PW], got[5*PW +: PW], got[4*PW +: PW]}),
          OW'({24'h1a1918, 24'h161514, 24'h060504, 24'h020100}));

      run_req(12, 1'b0, 5, "bp", got);
      run_req(25, 1'b0, 0, "oor", got);

      // Reset in the 4th FETCH cycle after tap 0 has landed.
      req_valid = 1'b1; req_addr = AW'(12); req_mode = 1'b0;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("midf_tap0", OW'(out_data[0 +: PW]), OW'(mem_m[6]));
      #1 rst_n = 1'b0;
      #1;
      chk("midf_rst_data", out_data, '0);
      chk("midf_rst_vld", OW'(out_valid), OW'(0));
      chk("midf_rst_err", OW'(out_err), OW'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1 chk("midf_rel_rdy", OW'(req_ready), OW'(1));
      @(negedge clk);
      run_req(12, 1'b0, 0, "post_rst", got);

      // Overwrite pixel 12 in the very cycle its tap is read.
      exp_d = win(12, 1'b0);
      req_valid = 1'b1; req_addr = AW'(12); req_mode = 1'b0;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 wr_en = 1'b1; wr_addr = AW'(12); wr_data = 24'hFFFFFF;
      @(posedge clk); #1 wr_en = 1'b0;
      mem_m[12] = 24'hFFFFFF;
      finish_req(exp_d, 1'b0, 10, 5, 2, "coll", got);
      chk("coll_ctr", OW'(got[4*PW +: PW]), OW'(24'h323130));
      run_req(12, 1'b1, 0, "coll_new", got);
      chk("coll_new_ctr", OW'(got[4*PW +: PW]), OW'(24'hFFFFFF));

      for (int it = 0; it < 20; it++) begin
         repeat ($urandom_range(0, 3)) wr_pix($urandom_range(0, 24), PW'($urandom));
         @(negedge clk);
         ra = $urandom_range(0, 31);
         rm = 1'($urandom_range(0, 1));
         run_req(ra, rm, $urandom_range(0, 3), $sformatf("rnd%0d", it), got);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/output_buffer_kxk.md
OUTPUT_BUFFER_KXK -- requirements
Module: output_buffer_kxk

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per channel sample.
REQ-002 SHALL have parameter OUT_CHANNELS, default 3, channels stored per pixel.
REQ-003 SHALL have parameter IN_WIDTH, default 5, and IN_HEIGHT, default 5, giving the unpadded feature-map size.
REQ-004 SHALL have parameter KERNEL, default 3, giving the odd window size (1, 3 or 5); PAD = (KERNEL-1)/2.
REQ-005 SHALL have parameter RAM_STYLE, default "auto", as the storage synthesis attribute.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-008 SHALL have port wr_en, input, 1 bit, the pixel write strobe.
REQ-009 SHALL have port wr_addr, input, clog2(IN_WIDTH*IN_HEIGHT) bits, the unpadded pixel index (row*IN_WIDTH+col).
REQ-010 SHALL have port wr_data, input, DATA_WIDTH*OUT_CHANNELS bits, all channels of one pixel, with channel c at [c*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have ports req_valid, input, 1 bit, and req_ready, output, 1 bit, the window request handshake.
REQ-012 SHALL have port req_addr, input, clog2(IN_WIDTH*IN_HEIGHT) bits, the window centre pixel index.
REQ-013 SHALL have port req_mode, input, 1 bit: 0 selects the full KxK window, 1 selects centre only (1x1).
REQ-014 SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit, the result handshake.
REQ-015 SHALL have port out_data, output, KERNEL*KERNEL*OUT_CHANNELS*DATA_WIDTH bits; tap t (row-major, 0..K*K-1) channel c occupies [(t*OUT_CHANNELS+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port out_err, output, 1 bit, flagging an out-of-range centre; it is qualified by out_valid.

Function
REQ-017 Storage SHALL hold IN_WIDTH*IN_HEIGHT unpadded pixel words; padding SHALL NOT be stored, and out-of-map taps SHALL read as zero.
REQ-018 The block SHALL use the FSM states IDLE, FETCH and HOLD; req_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, req_valid=1 SHALL latch req_addr and req_mode, compute centre row/col once, clear out_data, and enter FETCH.
REQ-020 FETCH SHALL issue one storage read per cycle for each in-map tap, in row-major order, using incremental row/col counters with no per-tap divide; the read data SHALL land in its tap slot one cycle later.
REQ-021 An out-of-map tap SHALL still take its cycle, issue no read, and leave its slot zero.
REQ-022 In full mode, FETCH SHALL last KERNEL*KERNEL cycles; in 1x1 mode it SHALL last 1 cycle, for the centre tap (K*K-1)/2 only, and all other slots SHALL stay zero.
REQ-023 Latency: with a request accepted on edge 0, out_valid SHALL rise after edge K*K+1 in full mode and after edge 2 in 1x1 mode.
REQ-024 In HOLD, out_valid SHALL be 1 and out_data/out_err SHALL be stable.
REQ-025 out_valid&out_ready SHALL return the FSM to IDLE; no new request is accepted in that same cycle.
REQ-026 A req_addr >= IN_WIDTH*IN_HEIGHT SHALL skip FETCH, go straight to HOLD with all-zero out_data and out_err=1, and issue no reads.
REQ-027 Writes SHALL be accepted in every state; a write and a read to the same address in the same cycle SHALL return the old data (read-first).
REQ-028 A write that lands on a tap already read during FETCH SHALL NOT alter out_data.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, out_valid 0, out_err 0, out_data 0 and counters 0, including mid-FETCH or mid-HOLD.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 req_ready SHALL be 1 from the first edge after rst_n deasserts.

Structure
REQ-032 Shared package output_buffer_pkg SHALL hold the FSM state encoding and the mode constants (MODE_KXK=0, MODE_1X1=1).
REQ-033 Storage SHALL be one sub-module, obuf_sdp_ram: simple dual-port, one write port and one registered read port, carrying the RAM_STYLE attribute.

Verification (DATA_WIDTH=8, OUT_CHANNELS=3, 5x5 map, KERNEL=3; pixel p channel c loaded with 4p+c)
REQ-034 Centre case: request addr 12, full mode -> taps 0..8 = pixels 6,7,8,11,12,13,16,17,18 (tap 4 channels = 48,49,50); out_valid on cycle 10; out_err 0.
REQ-035 Corner case: request addr 0, full mode -> taps 0,1,2,3,6 all zero; taps 4,5,7,8 = pixels 0,1,5,6.
REQ-036 Centre-only case: request addr 7, 1x1 mode -> tap 4 = 28,29,30, all else zero; out_valid on cycle 2.
REQ-037 Backpressure and range error: hold out_ready=0 for 5 cycles -> out_data stable and req_ready 0; then request addr 25 -> zero data, out_err 1, out_valid on cycle 1.
REQ-038 Reset and write collision: pulse rst_n low in the 4th FETCH cycle -> outputs 0 at once, req_ready 1 after release, RAM keeps its data; write pixel 12 with 0xFF during its fetch cycle -> old value 48,49,50 is returned.
